memref_port_arb: RTL and testbench

MEMREF_PORT_ARB -- requirements
Module: memref_port_arb

---
 rtl/memref_arb_pkg.sv | 22 ++
 rtl/memref_port_arb_rr_pick.sv | 35 +++
 rtl/memref_port_arb.sv | 169 ++++++++++++++++
 tb/tb_memref_port_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memref_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : memref_arb_pkg
// Brief    : Shared types and default constants for the memref port arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package memref_arb_pkg;

   localparam int C_DEF_WIDTH     = 32;
   localparam int C_DEF_ADDR_W    = 10;
   localparam int C_DEF_MAX_BURST = 16;

   // ARB: round-robin among all requesters; OWNED: one requester holds the port
   typedef enum logic [0:0] {
      ARB   = 1'b0,
      OWNED = 1'b1
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/memref_port_arb_rr_pick.sv
//------------------------------------------------------------------------------
// Module   : rr_pick
// Brief    : Combinational round-robin picker. Returns the one-hot grant for
//            the first asserted request at or after i_ptr, wrapping around.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
   parameter int NREQ  = 2,
   parameter int PTR_W = 1
) (
   input  logic [NREQ-1:0]  i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [NREQ-1:0]  o_gnt
);

   logic [2*NREQ-1:0] w_req_dbl;
   logic [NREQ-1:0]   w_req_rot;
   logic [NREQ-1:0]   w_gnt_rot;
   logic [2*NREQ-1:0] w_gnt_dbl;

   // Rotate requests right by ptr so the search start lands on bit 0, take the
   // lowest set bit, then rotate the one-hot result back into place.
   always_comb begin
      w_req_dbl = {i_req, i_req} >> i_ptr;
      w_req_rot = w_req_dbl[NREQ-1:0];
      w_gnt_rot = w_req_rot & (~w_req_rot + NREQ'(1));
      w_gnt_dbl = {w_gnt_rot, w_gnt_rot} << i_ptr;
      o_gnt     = w_gnt_dbl[2*NREQ-1:NREQ];
   end

endmodule

`default_nettype wire

// File: rtl/memref_port_arb.sv
//------------------------------------------------------------------------------
// Module   : memref_port_arb
// Brief    : Arbitrates NREQ requesters onto one single-port memref with
//            round-robin selection and bounded lock (burst) ownership.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module memref_port_arb
   import memref_arb_pkg::*;
#(
   parameter int WIDTH     = C_DEF_WIDTH,
   parameter int ADDR_W    = C_DEF_ADDR_W,
   parameter int NREQ      = 2,
   parameter int MAX_BURST = C_DEF_MAX_BURST
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_en,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ-1:0]        req_lock,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*WIDTH-1:0]  req_wr_data,
   output logic [NREQ-1:0]        req_gnt,
   output logic [NREQ-1:0]        req_rd_valid,
   output logic [WIDTH-1:0]       req_rd_data,
   output logic                   mem_rd_en,
   output logic                   mem_wr_en,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [WIDTH-1:0]       mem_wr_data,
   input  logic [WIDTH-1:0]       mem_rd_data
);

   localparam int PTR_W  = $clog2(NREQ);
   localparam int BCNT_W = $clog2(MAX_BURST + 1);
   localparam logic [PTR_W-1:0]  C_LAST_IDX = PTR_W'(NREQ - 1);
   localparam logic [BCNT_W-1:0] C_MAX_CNT  = BCNT_W'(MAX_BURST);

   arb_state_t         r_state,     w_state_nxt;
   logic [PTR_W-1:0]   r_ptr,       w_ptr_nxt;
   logic [PTR_W-1:0]   r_owner,     w_owner_nxt;
   logic [BCNT_W-1:0]  r_burst_cnt, w_burst_nxt;
   logic [NREQ-1:0]    r_rd_valid;

   logic [NREQ-1:0]    w_rr_gnt;
   logic [NREQ-1:0]    w_gnt_raw;
   logic [NREQ-1:0]    w_gnt;
   logic [PTR_W-1:0]   w_rr_idx;
   logic [PTR_W-1:0]   w_rr_inc;
   logic [PTR_W-1:0]   w_owner_inc;
   logic [PTR_W-1:0]   w_sel_idx;
   logic [BCNT_W-1:0]  w_burst_inc;
   logic               w_sel_we;
   logic [ADDR_W-1:0]  w_sel_addr;
   logic [WIDTH-1:0]   w_sel_wd;

   rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .i_req (req_en),
      .i_ptr (r_ptr),
      .o_gnt (w_rr_gnt)
   );

   // Encode the round-robin winner to an index; pick the source of the access
   always_comb begin
      w_rr_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_rr_gnt[i]) begin
            w_rr_idx = PTR_W'(i);
         end
      end
      w_rr_inc    = (w_rr_idx == C_LAST_IDX) ? '0 : w_rr_idx + PTR_W'(1);
      w_owner_inc = (r_owner == C_LAST_IDX) ? '0 : r_owner + PTR_W'(1);
      w_burst_inc = r_burst_cnt + BCNT_W'(1);
      w_sel_idx   = (r_state == OWNED) ? r_owner : w_rr_idx;
   end

   // Route the selected requester's op, address and data to the memref
   always_comb begin
      w_sel_we   = 1'b0;
      w_sel_addr = '0;
      w_sel_wd   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_sel_idx == PTR_W'(i)) begin
            w_sel_we   = req_we[i];
            w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_wd   = req_wr_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next-state logic: round-robin in ARB, exclusive owner service in OWNED
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      w_burst_nxt = r_burst_cnt;
      w_gnt_raw   = '0;
      case (r_state)
         ARB: begin
            w_gnt_raw = w_rr_gnt;
            if (|w_rr_gnt) begin
               // A one-grant burst limit means a lock can never extend ownership
               if (req_lock[w_rr_idx] && (MAX_BURST > 1)) begin
                  w_state_nxt = OWNED;
                  w_owner_nxt = w_rr_idx;
                  w_burst_nxt = BCNT_W'(1);
               end else begin
                  w_ptr_nxt = w_rr_inc;
               end
            end
         end
         OWNED: begin
            if (req_en[r_owner]) begin
               w_gnt_raw[r_owner] = 1'b1;
               w_burst_nxt        = w_burst_inc;
               if (!req_lock[r_owner] || (w_burst_inc == C_MAX_CNT)) begin
                  w_state_nxt = ARB;
                  w_ptr_nxt   = w_owner_inc;
                  w_burst_nxt = '0;
               end
            end else begin
               // Owner went idle: release without granting anyone this cycle
               w_state_nxt = ARB;
               w_ptr_nxt   = w_owner_inc;
               w_burst_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = ARB;
         end
      endcase
   end

   // Grants and memref strobes are suppressed while reset is held
   always_comb begin
      w_gnt        = w_gnt_raw & {NREQ{rst}};
      req_gnt      = w_gnt;
      mem_rd_en    = (|w_gnt) & ~w_sel_we;
      mem_wr_en    = (|w_gnt) & w_sel_we;
      mem_addr     = w_sel_addr;
      mem_wr_data  = w_sel_wd;
      // Gating with rst hides a read whose data would land while reset is held
      req_rd_valid = r_rd_valid & {NREQ{rst}};
      req_rd_data  = mem_rd_data;
   end

   // State, pointer, owner, burst count and read-valid registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ARB;
         r_ptr       <= '0;
         r_owner     <= '0;
         r_burst_cnt <= '0;
         r_rd_valid  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_owner     <= w_owner_nxt;
         r_burst_cnt <= w_burst_nxt;
         r_rd_valid  <= w_gnt & ~req_we;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_memref_port_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_memref_port_arb
// Brief    : Scoreboard bench for memref_port_arb with a reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_memref_port_arb;

   localparam int N  = 2;
   localparam int W  = 32;
   localparam int AW = 10;
   localparam int MB = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_en, req_we, req_lock;
   logic [N*AW-1:0] req_addr;
   logic [N*W-1:0]  req_wr_data;
   logic [N-1:0]    req_gnt, req_rd_valid;
   logic [W-1:0]    req_rd_data;
   logic            mem_rd_en, mem_wr_en;
   logic [AW-1:0]   mem_addr;
   logic [W-1:0]    mem_wr_data;
   logic [W-1:0]    mem_rd_data;

   always #5 clk = ~clk;

   memref_port_arb #(
      .WIDTH(W), .ADDR_W(AW), .NREQ(N), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .rst(rst),
      .req_en(req_en), .req_we(req_we), .req_lock(req_lock),
      .req_addr(req_addr), .req_wr_data(req_wr_data),
      .req_gnt(req_gnt), .req_rd_valid(req_rd_valid), .req_rd_data(req_rd_data),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   function automatic logic [W-1:0] init_val(int a);
      return 32'h1357_9BDF ^ (32'(a) * 32'h9E37_79B1);
   endfunction

   // Memref with one-cycle read latency; unwritten words return init_val
   logic [W-1:0] tb_mem [1024];
   bit           tb_wr  [1024];
   always @(posedge clk) begin
      if (mem_wr_en) begin
         tb_mem[mem_addr] <= mem_wr_data;
         tb_wr[mem_addr]  <= 1'b1;
      end
      if (mem_rd_en)
         mem_rd_data <= tb_wr[mem_addr] ? tb_mem[mem_addr] : init_val(int'(mem_addr));
   end

   typedef struct {
      int            cyc;
      logic [N-1:0]  gnt;
      logic          rd_en;
      logic          wr_en;
      logic [AW-1:0] addr;
      logic [W-1:0]  wd;
   } gexp_t;

   typedef struct {
      int           cyc;
      logic [N-1:0] vld;
      logic [W-1:0] data;
   } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];

   // Reference model state
   logic [W-1:0] m_mem [1024];
   bit           m_wr  [1024];
   bit           m_locked;
   int           m_owner, m_ptr, m_burst;

   // Stimulus for the next cycle
   bit            d_rst;
   logic [N-1:0]  d_en, d_we, d_lock;
   logic [AW-1:0] d_addr [N];
   logic [W-1:0]  d_wd   [N];

   int cyc     = 0;
   int n_tests = 0;
   int n_fail  = 0;
   int last_g;
   bit done    = 0;

   task automatic step();
      int    g;
      gexp_t e;
      rst      = d_rst;
      req_en   = d_en;
      req_we   = d_we;
      req_lock = d_lock;
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW]   = d_addr[i];
         req_wr_data[i*W +: W]  = d_wd[i];
      end
      cyc++;
      // A read whose data is due in a reset cycle is never reported
      if (!d_rst)
         while (rq.size() > 0 && rq[0].cyc == cyc) rq.delete(0);
      g = -1;
      if (!d_rst) begin
         m_locked = 0; m_ptr = 0; m_owner = 0; m_burst = 0;
      end else if (m_locked) begin
         if (d_en[m_owner]) begin
            g = m_owner;
            m_burst++;
            if (!d_lock[m_owner] || m_burst == MB) begin
               m_locked = 0;
               m_ptr    = (m_owner + 1) % N;
            end
         end else begin
            m_locked = 0;
            m_ptr    = (m_owner + 1) % N;
         end
      end else begin
         for (int k = 0; k < N; k++)
            if (g < 0 && d_en[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         if (g >= 0) begin
            if (d_lock[g] && MB > 1) begin
               m_locked = 1; m_owner = g; m_burst = 1;
            end else begin
               m_ptr = (g + 1) % N;
            end
         end
      end
      e.cyc = cyc; e.gnt = '0; e.rd_en = 0; e.wr_en = 0; e.addr = '0; e.wd = '0;
      if (g >= 0) begin
         e.gnt   = N'(1) << g;
         e.wr_en = d_we[g];
         e.rd_en = !d_we[g];
         e.addr  = d_addr[g];
         e.wd    = d_wd[g];
         if (d_we[g]) begin
            m_mem[d_addr[g]] = d_wd[g];
            m_wr[d_addr[g]]  = 1;
         end else begin
            rq.push_back('{cyc + 1, N'(1) << g,
                           m_wr[d_addr[g]] ? m_mem[d_addr[g]] : init_val(int'(d_addr[g]))});
         end
      end
      gq.push_back(e);
      last_g = g;
      @(negedge clk);
   endtask

   task automatic idle();
      d_en = '0; d_we = '0; d_lock = '0;
   endtask

   // Monitor: compares grant/strobes each cycle and read returns when due
   initial begin
      gexp_t e;
      rexp_t r;
      @(negedge clk);
      #2;
      while (!done) begin
         if (gq.size() > 0 && gq[0].cyc == cyc) begin
            e = gq.pop_front();
            n_tests++;
            if ({req_gnt, mem_rd_en, mem_wr_en} !== {e.gnt, e.rd_en, e.wr_en}) begin
               n_fail++;
               $display("FAIL gnt cyc=%0d: got gnt=%b rd_en=%b wr_en=%b, want gnt=%b rd_en=%b wr_en=%b",
                        cyc, req_gnt, mem_rd_en, mem_wr_en, e.gnt, e.rd_en, e.wr_en);
            end
            if (e.gnt != '0) begin
               n_tests++;
               if (mem_addr !== e.addr || (e.wr_en && mem_wr_data !== e.wd)) begin
                  n_fail++;
                  $display("FAIL memaccess cyc=%0d: got addr=%0d wd=%h, want addr=%0d wd=%h",
                           cyc, mem_addr, mem_wr_data, e.addr, e.wd);
               end
            end
         end
         n_tests++;
         if (rq.size() > 0 && rq[0].cyc == cyc) begin
            r = rq.pop_front();
            if (req_rd_valid !== r.vld || req_rd_data !== r.data) begin
               n_fail++;
               $display("FAIL rdret cyc=%0d: got vld=%b data=%h, want vld=%b data=%h",
                        cyc, req_rd_valid, req_rd_data, r.vld, r.data);
            end
         end else if (req_rd_valid !== '0) begin
            n_fail++;
            $display("FAIL rdvalid cyc=%0d: got vld=%b, want vld=00", cyc, req_rd_valid);
         end
         @(negedge clk);
         #2;
      end
   end

   // Driver: directed scenarios, then randomized traffic
   initial begin
      bit pend [N];
      for (int i = 0; i < N; i++) begin
         d_addr[i] = '0; d_wd[i] = '0; pend[i] = 0;
      end
      idle();
      d_rst = 0;
      rst = 0; req_en = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wr_data = '0;
      @(negedge clk);

      // Reset held with both requesting: nothing granted; then requester 0 first
      d_en = 2'b11;
      repeat (3) step();
      d_rst = 1;
      step();

      // Simultaneous reads of 5 and 9 alternate
      d_rst = 0; idle(); step(); d_rst = 1;
      d_addr[0] = 10'd5; d_addr[1] = 10'd9; d_en = 2'b11;
      repeat (8) step();

      // Locked burst by requester 0 capped at MB grants
      d_rst = 0; idle(); step(); d_rst = 1;
      d_en = 2'b11; d_lock = 2'b01;
      repeat (22) step();

      // Early release: owner drops its request for one cycle
      d_rst = 0; idle(); step(); d_rst = 1;
      d_en = 2'b11; d_lock = 2'b01; step();
      d_en = 2'b10; step();
      step();
      d_en = 2'b11; d_lock = 2'b00; step();

      // Requester 1 writes then reads the top address
      idle(); step();
      d_en = 2'b10; d_we = 2'b10; d_addr[1] = 10'd1023; d_wd[1] = 32'hDEAD_BEEF; step();
      d_we = 2'b00; step();
      idle(); step();

      // Reset in the cycle after a read grant
      d_en = 2'b01; d_addr[0] = 10'd5; step();
      idle(); d_rst = 0; step();
      d_rst = 1; step(); step();

      // Randomized traffic; each request is held until the model grants it
      for (int c = 0; c < 3000; c++) begin
         d_rst = ($urandom_range(0, 199) != 0);
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 3) != 0) begin
               pend[i]   = 1;
               d_we[i]   = ($urandom_range(0, 2) == 0);
               d_lock[i] = ($urandom_range(0, 2) != 0);
               d_addr[i] = ($urandom_range(0, 7) == 0) ? 10'd1023 : 10'($urandom_range(0, 15));
               d_wd[i]   = $urandom;
            end
            d_en[i] = pend[i];
         end
         step();
         if (last_g >= 0) pend[last_g] = 0;
      end

      d_rst = 1; idle();
      repeat (3) step();
      done = 1;
      #5;
      n_tests++;
      if (rq.size() != 0) begin
         n_fail++;
         $display("FAIL rdpending: got %0d outstanding reads, want 0", rq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
